// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock controller for the 5-stage MIPS core.
// Resolves hazards that forwarding cannot cover:
//   - load-use: one bubble between a load in EX and its dependent in ID
//   - taken EX-stage branch: squash the two younger instructions
//   - data-memory wait: freeze the whole pipe until the access completes
// Decisions are combinational from (state, inputs). Only the FSM state,
// the wait-cycle counter, the sticky timeout flag and the stall-cycle
// counter are registered.
module hazard_ctrl #(
  parameter int REG_AW      = 5,   // register-index width
  parameter int MEM_TIMEOUT = 16,  // consecutive wait cycles before mem_err (>=2)
  parameter int CNT_W       = 16   // stall_cnt width
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] IF_ID_rs,
  input  logic [REG_AW-1:0] IF_ID_rt,
  input  logic              IF_ID_uses_rt,
  input  logic [REG_AW-1:0] ID_EX_rt,
  input  logic              ID_EX_memread,
  input  logic              EX_br_taken,
  input  logic              MEM_req,
  input  logic              MEM_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              pipe_hold,
  output logic              mem_wb_bubble,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Wide enough to hold MEM_TIMEOUT itself; the counter saturates there.
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_to_next;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_use;
  logic w_mem_hold;

  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_pipe_hold;
  logic w_mem_wb_bubble;

  // Hazard detection. Register $zero is never a real dependency, so a
  // load targeting r0 cannot stall anything.
  always_comb begin
    w_rs_hit   = (ID_EX_rt == IF_ID_rs);
    w_rt_hit   = IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt);
    w_load_use = ID_EX_memread && (ID_EX_rt != '0) && (w_rs_hit || w_rt_hit);
    // Once waiting, the freeze lasts until ready, even if the request
    // line wobbles, because the MEM stage is frozen on that access.
    w_mem_hold = !MEM_ready && (MEM_req || (r_state == MEM_WAIT));
  end

  // Per-cycle control decision, priority: memory wait > branch > load-use.
  always_comb begin
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_pipe_hold     = 1'b0;
    w_mem_wb_bubble = 1'b0;
    w_state_next    = RUN;

    if (w_mem_hold) begin
      // Whole pipe frozen; a taken branch in EX is frozen with it and
      // will be seen again once the memory releases.
      w_pc_write      = 1'b0;
      w_if_id_write   = 1'b0;
      w_pipe_hold     = 1'b1;
      w_mem_wb_bubble = 1'b1;
      w_state_next    = MEM_WAIT;
    end else if (r_state == MEM_WAIT) begin
      // Release cycle: memory completed, pipe runs normally again.
      w_state_next = RUN;
    end else if (EX_br_taken) begin
      // Squash IF/ID and ID/EX; also kills a dependent load-use victim.
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_state_next  = RUN;
    end else if ((r_state == RUN) && w_load_use) begin
      // Insert exactly one bubble; LOAD_STALL suppresses a second one
      // because the load has moved on to MEM by then.
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
      w_state_next  = LOAD_STALL;
    end

    // While reset is asserted every control output is forced low,
    // without waiting for a clock edge.
    if (rst_i) begin
      w_pc_write      = 1'b0;
      w_if_id_write   = 1'b0;
      w_if_id_flush   = 1'b0;
      w_id_ex_flush   = 1'b0;
      w_pipe_hold     = 1'b0;
      w_mem_wb_bubble = 1'b0;
      w_state_next    = RUN;
    end
  end

  // Consecutive wait-cycle count, saturating at the timeout limit.
  always_comb begin
    w_to_next = '0;
    if (w_mem_hold) begin
      if (r_to_cnt == TO_LIMIT) begin
        w_to_next = r_to_cnt;
      end else begin
        w_to_next = r_to_cnt + TO_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Timeout tracking: mem_err latches once the wait run reaches the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt  <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_to_cnt <= w_to_next;
      if (w_to_next == TO_LIMIT) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign pc_write      = w_pc_write;
  assign if_id_write   = w_if_id_write;
  assign if_id_flush   = w_if_id_flush;
  assign id_ex_flush   = w_id_ex_flush;
  assign pipe_hold     = w_pipe_hold;
  assign mem_wb_bubble = w_mem_wb_bubble;
  assign mem_err       = r_mem_err;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of single-cycle vectors from a clean RUN
// state, hand-written multi-cycle sequences, then random traffic, all
// checked against a rule-level reference model. stall_cnt is built
// narrow (4 bits) so saturation is reachable quickly.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int TO = 16;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          urt;
    logic [AW-1:0] exrt;
    logic          mr;
    logic          br;
    logic          req;
    logic          rdy;
  } vin_t;

  typedef struct {
    vin_t       v;
    logic [5:0] exp;
  } row_t;

  // Output pattern {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_bubble}
  localparam logic [5:0] O_DEF  = 6'b110000;
  localparam logic [5:0] O_LU   = 6'b000100;
  localparam logic [5:0] O_BR   = 6'b111100;
  localparam logic [5:0] O_MEM  = 6'b000011;
  localparam logic [5:0] O_ZERO = 6'b000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
  logic          IF_ID_uses_rt, ID_EX_memread, EX_br_taken, MEM_req, MEM_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_bubble, mem_err;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .IF_ID_rs     (IF_ID_rs),
    .IF_ID_rt     (IF_ID_rt),
    .IF_ID_uses_rt(IF_ID_uses_rt),
    .ID_EX_rt     (ID_EX_rt),
    .ID_EX_memread(ID_EX_memread),
    .EX_br_taken  (EX_br_taken),
    .MEM_req      (MEM_req),
    .MEM_ready    (MEM_ready),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .pipe_hold    (pipe_hold),
    .mem_wb_bubble(mem_wb_bubble),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, described in pipeline terms.
  bit m_in_wait;    // a memory access is outstanding and the pipe is frozen
  bit m_bubbled;    // the previous cycle already inserted the load-use bubble
  int m_wait_len;   // length of the current run of frozen cycles
  bit m_err;
  int m_stalls;

  function automatic vin_t mk(int rs, int rt, bit urt, int exrt, bit mr, bit br, bit req, bit rdy);
    vin_t v;
    v.rs = AW'(rs); v.rt = AW'(rt); v.urt = urt; v.exrt = AW'(exrt);
    v.mr = mr; v.br = br; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  function automatic bit model_frozen(vin_t v);
    return !v.rdy && (v.req || m_in_wait);
  endfunction

  function automatic logic [5:0] model_out(vin_t v);
    bit dep;
    dep = v.mr && (v.exrt != 0) && ((v.exrt == v.rs) || (v.urt && (v.exrt == v.rt)));
    if (model_frozen(v)) return O_MEM;
    if (m_in_wait)       return O_DEF;
    if (v.br)            return O_BR;
    if (dep && !m_bubbled) return O_LU;
    return O_DEF;
  endfunction

  function automatic void model_clock(vin_t v, logic [5:0] o);
    bit fr;
    fr = model_frozen(v);
    m_bubbled = (o == O_LU);
    m_in_wait = fr;
    if (fr) begin
      m_wait_len = m_wait_len + 1;
      if (m_wait_len >= TO) m_err = 1'b1;
    end else begin
      m_wait_len = 0;
    end
    if (!o[5] && (m_stalls < CNT_MAX)) m_stalls = m_stalls + 1;
  endfunction

  function automatic void model_reset();
    m_in_wait = 0; m_bubbled = 0; m_wait_len = 0; m_err = 0; m_stalls = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_wb_bubble};
  endfunction

  task automatic apply(input vin_t v);
    IF_ID_rs = v.rs; IF_ID_rt = v.rt; IF_ID_uses_rt = v.urt; ID_EX_rt = v.exrt;
    ID_EX_memread = v.mr; EX_br_taken = v.br; MEM_req = v.req; MEM_ready = v.rdy;
  endtask

  // One clock cycle: drive at negedge, compare mid-cycle, advance the model at posedge.
  task automatic step(input vin_t v, input string tag, output logic [5:0] act);
    logic [5:0] e;
    @(negedge clk);
    apply(v);
    #1;
    e = model_out(v);
    act = outs();
    chk({tag, ".ctl"}, 32'(act), 32'(e));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stalls));
    chk({tag, ".mem_err"}, 32'(mem_err), 32'(m_err));
    $display("%0t %s rs=%0d rt=%0d urt=%b exrt=%0d mr=%b br=%b req=%b rdy=%b ctl=%b cnt=%0d err=%b",
             $time, tag, v.rs, v.rt, v.urt, v.exrt, v.mr, v.br, v.req, v.rdy, act, stall_cnt, mem_err);
    @(posedge clk);
    model_clock(v, e);
  endtask

  // Reset asserted between edges; outputs must drop at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({tag, ".rst_ctl"}, 32'(outs()), 32'(O_ZERO));
    chk({tag, ".rst_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, ".rst_err"}, 32'(mem_err), 32'd0);
    $display("%0t %s reset asserted ctl=%b cnt=%0d err=%b", $time, tag, outs(), stall_cnt, mem_err);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1));
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  row_t rows[12];
  vin_t idle;
  logic [5:0] act;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();

    // Reset at time zero with a load-use pattern on the inputs: still all-zero.
    rst = 1'b1;
    apply(mk(8, 0, 0, 8, 1, 0, 0, 1));
    #2;
    chk("init.rst_ctl", 32'(outs()), 32'(O_ZERO));
    chk("init.rst_cnt", 32'(stall_cnt), 32'd0);
    chk("init.rst_err", 32'(mem_err), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Single-cycle vectors, each applied from RUN after an idle cycle.
    rows[0]  = '{v: mk(8, 0, 0, 8, 1, 0, 0, 1), exp: O_LU};   // lw rs dependency
    rows[1]  = '{v: mk(3, 9, 1, 9, 1, 0, 0, 1), exp: O_LU};   // lw rt dependency
    rows[2]  = '{v: mk(3, 9, 0, 9, 1, 0, 0, 1), exp: O_DEF};  // rt not a source
    rows[3]  = '{v: mk(0, 0, 1, 0, 1, 0, 0, 1), exp: O_DEF};  // $zero never stalls
    rows[4]  = '{v: mk(8, 0, 0, 8, 0, 0, 0, 1), exp: O_DEF};  // not a load
    rows[5]  = '{v: mk(8, 0, 0, 8, 1, 1, 0, 1), exp: O_BR};   // branch squashes load-use
    rows[6]  = '{v: mk(1, 2, 1, 5, 0, 1, 0, 1), exp: O_BR};   // branch alone
    rows[7]  = '{v: mk(1, 2, 0, 5, 0, 0, 1, 0), exp: O_MEM};  // memory wait
    rows[8]  = '{v: mk(8, 0, 0, 8, 1, 1, 1, 0), exp: O_MEM};  // wait beats branch and load-use
    rows[9]  = '{v: mk(1, 2, 0, 5, 0, 0, 1, 1), exp: O_DEF};  // zero-wait access
    rows[10] = '{v: mk(1, 2, 0, 5, 0, 0, 0, 0), exp: O_DEF};  // ready low without request
    rows[11] = '{v: mk(4, 7, 1, 7, 1, 0, 0, 1), exp: O_LU};   // rt dependency, distinct rs
    for (int i = 0; i < 12; i++) begin
      step(idle, $sformatf("tbl%0d.idle", i), act);
      step(rows[i].v, $sformatf("tbl%0d", i), act);
      chk($sformatf("tbl%0d.expect", i), 32'(act), 32'(rows[i].exp));
    end
    step(idle, "tbl.tail", act);

    // Load-use: one bubble, then defaults, stall_cnt=1.
    do_reset("s1");
    step(mk(8, 0, 0, 8, 1, 0, 0, 1), "s1.stall", act);
    chk("s1.stall_exp", 32'(act), 32'(O_LU));
    step(mk(8, 0, 0, 8, 1, 0, 0, 1), "s1.after", act);
    chk("s1.after_exp", 32'(act), 32'(O_DEF));
    step(idle, "s1.idle", act);
    chk("s1.cnt", 32'(stall_cnt), 32'd1);

    // $zero load never stalls.
    for (int i = 0; i < 3; i++) step(mk(0, 0, 1, 0, 1, 0, 0, 1), $sformatf("s2.%0d", i), act);
    chk("s2.cnt", 32'(stall_cnt), 32'd1);

    // Branch in LOAD_STALL still flushes.
    step(mk(8, 0, 0, 8, 1, 0, 0, 1), "s3.stall", act);
    step(mk(8, 0, 0, 8, 1, 1, 0, 1), "s3.br", act);
    chk("s3.br_exp", 32'(act), 32'(O_BR));

    // Three wait cycles then release: stall_cnt advances by exactly 3.
    do_reset("s4");
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 0, 0, 0, 0, 1, 1, 0), $sformatf("s4.w%0d", i), act);
      chk($sformatf("s4.w%0d_exp", i), 32'(act), 32'(O_MEM));
    end
    step(mk(0, 0, 0, 0, 0, 1, 1, 1), "s4.rel", act);
    chk("s4.rel_exp", 32'(act), 32'(O_DEF));
    step(idle, "s4.idle", act);
    chk("s4.cnt", 32'(stall_cnt), 32'd3);

    // Twenty wait cycles: mem_err appears after the 16th, stays, counter saturates.
    for (int i = 0; i < 20; i++) step(mk(0, 0, 0, 0, 0, 0, 1, 0), $sformatf("s5.w%0d", i), act);
    step(mk(0, 0, 0, 0, 0, 0, 1, 1), "s5.rel", act);
    step(idle, "s5.idle", act);
    chk("s5.err_sticky", 32'(mem_err), 32'd1);
    chk("s5.cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));

    // Reset in the middle of a memory wait.
    step(mk(0, 0, 0, 0, 0, 0, 1, 0), "s6.w0", act);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0), "s6.w1", act);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("s6.rst_ctl", 32'(outs()), 32'(O_ZERO));
    chk("s6.rst_err", 32'(mem_err), 32'd0);
    chk("s6.rst_cnt", 32'(stall_cnt), 32'd0);
    apply(idle);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    step(mk(8, 0, 0, 8, 1, 0, 0, 1), "s6.run", act);
    chk("s6.run_exp", 32'(act), 32'(O_LU));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      vin_t v;
      v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30),
             ($urandom_range(0, 99) < 60));
      if ($urandom_range(0, 99) == 0) do_reset($sformatf("r%0d", i));
      step(v, $sformatf("r%0d", i), act);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
